// File: rtl/pe_pkg.sv
// Shared types and constants for the request scheduler.
// Used by pri_enc8 and pe_req_sched.
package pe_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } sched_state_t;

    // One-hot expansion of a grant index.
    function automatic req_vec_t idx2oh(input req_idx_t idx);
        req_vec_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8:3 priority encoder; bit 7 has highest priority.
// Returns 0 when no bit is set, so callers must qualify with |avec.
module pri_enc8
    import pe_pkg::*;
(
    input  req_vec_t avec,
    output req_idx_t code
);

    // Highest set bit wins.
    always_comb begin
        code = '0;
        priority casez (avec)
            8'b1???????: code = 3'd7;
            8'b01??????: code = 3'd6;
            8'b001?????: code = 3'd5;
            8'b0001????: code = 3'd4;
            8'b00001???: code = 3'd3;
            8'b000001??: code = 3'd2;
            8'b0000001?: code = 3'd1;
            default:     code = 3'd0;
        endcase
    end

endmodule

// File: rtl/pe_req_sched.sv
// Request capture and one-at-a-time grant sequencer with valid/ready grant.
// Optional macro PE_REQ_EDGE_EN: capture rising edges of req instead of levels.
module pe_req_sched
    import pe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    output logic       grant_valid,
    input  logic       grant_ready,
    output logic [2:0] grant_idx,
    output logic [7:0] pending,
    output logic       dropped
);

    sched_state_t state_q;
    req_vec_t     pending_q, pending_d;
    req_idx_t     grant_idx_q;
    logic         grant_valid_q;
    logic         dropped_q, dropped_d;

    req_vec_t     new_req;
    req_vec_t     clr;
    req_vec_t     avec;
    req_idx_t     enc_code;
    logic         hs;

`ifdef PE_REQ_EDGE_EN
    req_vec_t     req_q;

    // Previous req sample for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    assign new_req = req & ~req_q;
`else
    assign new_req = req;
`endif

    assign hs   = grant_valid_q & grant_ready;
    assign clr  = hs ? idx2oh(grant_idx_q) : '0;
    assign avec = pending_q & ~mask;

    pri_enc8 u_enc (
        .avec (avec),
        .code (enc_code)
    );

    // Next pending vector: set wins over clear; flag merges into pending bits.
    always_comb begin
        pending_d = (pending_q & ~clr) | new_req;
        dropped_d = |(new_req & pending_q & ~clr);
    end

    // Pending register and merge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    // Grant FSM with registered valid and index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|avec) begin
                        grant_idx_q   <= enc_code;
                        grant_valid_q <= 1'b1;
                        state_q       <= S_GRANT;
                    end else begin
                        grant_valid_q <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (grant_ready) begin
                        grant_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    grant_valid_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign pending     = pending_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_pe_req_sched.sv
// Directed bench for pe_req_sched.
// Works with or without PE_REQ_EDGE_EN defined.
module tb_pe_req_sched;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       grant_valid;
    logic       grant_ready;
    logic [2:0] grant_idx;
    logic [7:0] pending;
    logic       dropped;

    int checks;
    int errors;

    pe_req_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mask        (mask),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_idx   (grant_idx),
        .pending     (pending),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        req         = '0;
        mask        = '0;
        grant_ready = 1'b0;

        // Reset state
        step();
        chk("rst_pending", pending, 8'h00);
        chk("rst_gv", {7'b0, grant_valid}, 8'h00);
        chk("rst_idx", {5'b0, grant_idx}, 8'h00);
        chk("rst_dropped", {7'b0, dropped}, 8'h00);
        rst = 1'b0;

        // Priority: 0x12 -> grant 4 then 1
        req = 8'h12;
        grant_ready = 1'b1;
        step();
        chk("pri_pending", pending, 8'h12);
        chk("pri_gv0", {7'b0, grant_valid}, 8'h00);
        req = 8'h00;
        step();
        chk("pri_gv1", {7'b0, grant_valid}, 8'h01);
        chk("pri_idx4", {5'b0, grant_idx}, 8'h04);
        step();
        chk("pri_pend_after4", pending, 8'h02);
        chk("pri_bubble", {7'b0, grant_valid}, 8'h00);
        step();
        chk("pri_gv2", {7'b0, grant_valid}, 8'h01);
        chk("pri_idx1", {5'b0, grant_idx}, 8'h01);
        step();
        chk("pri_pend_empty", pending, 8'h00);
        grant_ready = 1'b0;

        // Async reset mid-grant with pending 0xA5
        req = 8'hA5;
        step();
        req = 8'h00;
        step();
        chk("ar_gv_before", {7'b0, grant_valid}, 8'h01);
        chk("ar_idx7", {5'b0, grant_idx}, 8'h07);
        chk("ar_pend_before", pending, 8'hA5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pending", pending, 8'h00);
        chk("ar_gv", {7'b0, grant_valid}, 8'h00);
        chk("ar_idx", {5'b0, grant_idx}, 8'h00);
        #1;
        rst = 1'b0;
        step();
        chk("ar_stay_idle", {7'b0, grant_valid}, 8'h00);

        // Backpressure: hold grant 0, then req[7] pulses
        req = 8'h01;
        step();
        req = 8'h00;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_gv", {7'b0, grant_valid}, 8'h01);
            chk("bp_hold_idx", {5'b0, grant_idx}, 8'h00);
            step();
        end
        req = 8'h80;
        step();
        req = 8'h00;
        chk("bp_pend81", pending, 8'h81);
        chk("bp_idx_still0", {5'b0, grant_idx}, 8'h00);
        grant_ready = 1'b1;
        step();
        chk("bp_pend80", pending, 8'h80);
        step();
        chk("bp_next_gv", {7'b0, grant_valid}, 8'h01);
        chk("bp_next_idx7", {5'b0, grant_idx}, 8'h07);
        step();
        chk("bp_empty", pending, 8'h00);
        grant_ready = 1'b0;
        step();

        // Mask: pending 0x81, mask 0x80
        mask = 8'h80;
        req = 8'h81;
        step();
        req = 8'h00;
        step();
        chk("mk_gv", {7'b0, grant_valid}, 8'h01);
        chk("mk_idx0", {5'b0, grant_idx}, 8'h00);
        grant_ready = 1'b1;
        step();
        chk("mk_pend80", pending, 8'h80);
        step();
        chk("mk_all_masked_gv", {7'b0, grant_valid}, 8'h00);
        chk("mk_ready_ignored", pending, 8'h80);
        grant_ready = 1'b0;
        mask = 8'h00;
        step();
        chk("mk_unmask_gv", {7'b0, grant_valid}, 8'h01);
        chk("mk_unmask_idx7", {5'b0, grant_idx}, 8'h07);
        mask = 8'h80;
        step();
        chk("mk_no_revoke_gv", {7'b0, grant_valid}, 8'h01);
        chk("mk_no_revoke_idx", {5'b0, grant_idx}, 8'h07);
        grant_ready = 1'b1;
        step();
        chk("mk_pend_empty", pending, 8'h00);
        grant_ready = 1'b0;
        mask = 8'h00;
        step();

        // Set wins over clear on bit 3
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        chk("sc_idx3", {5'b0, grant_idx}, 8'h03);
        grant_ready = 1'b1;
        req = 8'h08;
        step();
        req = 8'h00;
        chk("sc_pend_kept", pending, 8'h08);
        chk("sc_dropped_none", {7'b0, dropped}, 8'h00);
        step();
        chk("sc_regrant_gv", {7'b0, grant_valid}, 8'h01);
        chk("sc_regrant_idx", {5'b0, grant_idx}, 8'h03);
        step();
        chk("sc_empty", pending, 8'h00);
        grant_ready = 1'b0;
        step();

        // Merge: pulses on bit 2 while pending
        mask = 8'hFF;
        req = 8'h04;
        step();
        chk("mg_first", {7'b0, dropped}, 8'h00);
        req = 8'h00;
        step();
        chk("mg_gap1", {7'b0, dropped}, 8'h00);
        req = 8'h04;
        step();
        chk("mg_pulse1", {7'b0, dropped}, 8'h01);
        req = 8'h00;
        step();
        chk("mg_gap2", {7'b0, dropped}, 8'h00);
        req = 8'h04;
        step();
        chk("mg_pulse2", {7'b0, dropped}, 8'h01);
        step();
`ifdef PE_REQ_EDGE_EN
        chk("mg_held1", {7'b0, dropped}, 8'h00);
`else
        chk("mg_held1", {7'b0, dropped}, 8'h01);
`endif
        step();
`ifdef PE_REQ_EDGE_EN
        chk("mg_held2", {7'b0, dropped}, 8'h00);
`else
        chk("mg_held2", {7'b0, dropped}, 8'h01);
`endif
        req = 8'h00;
        step();
        chk("mg_release", {7'b0, dropped}, 8'h00);
        chk("mg_pend", pending, 8'h04);
        chk("mg_no_grant", {7'b0, grant_valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
